// File: rtl/game_pkg.sv
// Shared types and widths for the game level/lives sequencer.
package game_pkg;

    localparam int LEVEL_W = 2;
    localparam int LIVES_W = 3;
    localparam int TIME_W  = 12;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_HIT       = 3'd2,
        ST_CLEARED   = 3'd3,
        ST_GAME_OVER = 3'd4,
        ST_WIN       = 3'd5
    } game_st_t;

endpackage

// File: rtl/frame_countdown.sv
// Frame-paced down-counter: loads a value, decrements on each tick and
// parks at zero. Flags when the count has reached zero.
module frame_countdown #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         load,
    input  logic [W-1:0] loadValue,
    input  logic         tick,
    output logic         zero,
    output logic [W-1:0] count
);

    // Load wins over tick; the count saturates at zero instead of wrapping.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/game_sequencer.sv
// Level/lives sequencer for the ball game. Enables one ball unit per level,
// freezes play after a hit or a cleared level, then re-deploys, advances or
// ends the game.
// Optional build macro LEVEL_TIMER_EN adds a per-level frame time budget
// whose expiry counts as a hit; without it timeLeft is tied to zero.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | after reset, waiting for startGame
// ST_PLAY      | current level's ball unit enabled, watching hits/clears
// ST_HIT       | player hit, freeze before re-deploy or game over
// ST_CLEARED   | level cleared, freeze before next level or win
// ST_GAME_OVER | no lives left, waiting for startGame
// ST_WIN       | last level cleared, waiting for startGame
module game_sequencer
    import game_pkg::*;
#(
    parameter int NUM_LEVELS        = 3,
    parameter int START_LIVES       = 3,
    parameter int FREEZE_FRAMES     = 60,
    parameter int LEVEL_TIME_FRAMES = 1800
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfFrame,
    input  logic                  startGame,
    input  logic                  col_player_ball,
    input  logic                  anyBallVisible,
    output logic [NUM_LEVELS-1:0] unitActive,
    output logic [LEVEL_W-1:0]    level,
    output logic [LIVES_W-1:0]    lives,
    output logic                  playerFreeze,
    output logic                  gameOver,
    output logic                  gameWon,
    output logic [TIME_W-1:0]     timeLeft
);

    localparam int FRZ_W = $clog2(FREEZE_FRAMES + 1);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);

    // Reject parameter values the fixed output widths cannot represent.
    if (NUM_LEVELS < 1 || NUM_LEVELS > 4) begin : g_bad_levels
        $error("game_sequencer: NUM_LEVELS must be 1..4");
    end
    if (START_LIVES < 1 || START_LIVES > 7) begin : g_bad_lives
        $error("game_sequencer: START_LIVES must be 1..7");
    end
    if (FREEZE_FRAMES < 1) begin : g_bad_freeze
        $error("game_sequencer: FREEZE_FRAMES must be at least 1");
    end
    if (LEVEL_TIME_FRAMES < 1 || LEVEL_TIME_FRAMES > 4095) begin : g_bad_time
        $error("game_sequencer: LEVEL_TIME_FRAMES must be 1..4095");
    end

    game_st_t                state;
    game_st_t                state_nxt;
    logic [LEVEL_W-1:0]      level_nxt;
    logic [LIVES_W-1:0]      lives_nxt;
    logic                    ball_seen;
    logic                    play_entry;
    logic                    freeze_entry;
    logic                    freezing;
    logic                    freeze_zero;
    logic                    timer_expired;
    logic [FRZ_W-1:0]        freeze_left_unused;
    logic [NUM_LEVELS-1:0]   unit_active_nxt;
    logic                    player_freeze_nxt;
    logic                    game_over_nxt;
    logic                    game_won_nxt;

    assign play_entry   = (state_nxt == ST_PLAY) && (state != ST_PLAY);
    assign freeze_entry = (state == ST_PLAY) && (state_nxt != ST_PLAY);
    assign freezing     = (state == ST_HIT) || (state == ST_CLEARED);

    // Freeze length between a hit/clear and the exit decision.
    frame_countdown #(
        .W (FRZ_W)
    ) u_freeze (
        .clk       (clk),
        .resetN    (resetN),
        .load      (freeze_entry),
        .loadValue (FRZ_W'(FREEZE_FRAMES)),
        .tick      (startOfFrame && freezing),
        .zero      (freeze_zero),
        .count     (freeze_left_unused)
    );

`ifdef LEVEL_TIMER_EN
    logic              timer_zero;
    logic [TIME_W-1:0] timer_count;

    // Per-level time budget; reloads on every PLAY entry, holds outside PLAY.
    frame_countdown #(
        .W (TIME_W)
    ) u_level_timer (
        .clk       (clk),
        .resetN    (resetN),
        .load      (play_entry),
        .loadValue (TIME_W'(LEVEL_TIME_FRAMES)),
        .tick      (startOfFrame && (state == ST_PLAY)),
        .zero      (timer_zero),
        .count     (timer_count)
    );

    assign timer_expired = timer_zero && (state == ST_PLAY);
    assign timeLeft      = timer_count;
`else
    assign timer_expired = 1'b0;
    assign timeLeft      = '0;
`endif

    // State register together with the level/lives bookkeeping.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= ST_IDLE;
            level <= '0;
            lives <= '0;
        end else begin
            state <= state_nxt;
            level <= level_nxt;
            lives <= lives_nxt;
        end
    end

    // Next-state decision; in PLAY a hit or timeout outranks a clear.
    always_comb begin
        state_nxt = state;
        level_nxt = level;
        lives_nxt = lives;
        unique case (state)
            ST_IDLE, ST_GAME_OVER, ST_WIN: begin
                if (startGame) begin
                    state_nxt = ST_PLAY;
                    level_nxt = '0;
                    lives_nxt = LIVES_W'(START_LIVES);
                end
            end
            ST_PLAY: begin
                if (col_player_ball || timer_expired) begin
                    state_nxt = ST_HIT;
                    lives_nxt = (lives == '0) ? '0 : lives - 1'b1;
                end else if (ball_seen && !anyBallVisible) begin
                    state_nxt = ST_CLEARED;
                end
            end
            ST_HIT: begin
                if (freeze_zero) begin
                    state_nxt = (lives == '0) ? ST_GAME_OVER : ST_PLAY;
                end
            end
            ST_CLEARED: begin
                if (freeze_zero) begin
                    if (level == LAST_LEVEL) begin
                        state_nxt = ST_WIN;
                    end else begin
                        state_nxt = ST_PLAY;
                        level_nxt = level + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // A clear only counts once the freshly deployed ball has been seen,
    // which hides the two-cycle deploy latency of the ball unit.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ball_seen <= 1'b0;
        end else if (play_entry) begin
            ball_seen <= 1'b0;
        end else if ((state == ST_PLAY) && anyBallVisible) begin
            ball_seen <= 1'b1;
        end
    end

    // Output decode from the upcoming state so the registered outputs
    // change on the same edge as the state.
    always_comb begin
        unit_active_nxt   = '0;
        player_freeze_nxt = 1'b0;
        game_over_nxt     = 1'b0;
        game_won_nxt      = 1'b0;
        unique case (state_nxt)
            ST_PLAY:              unit_active_nxt   = NUM_LEVELS'(1) << level_nxt;
            ST_HIT, ST_CLEARED:   player_freeze_nxt = 1'b1;
            ST_GAME_OVER:         game_over_nxt     = 1'b1;
            ST_WIN:               game_won_nxt      = 1'b1;
            default:              unit_active_nxt   = '0;
        endcase
    end

    // Registered status and enable outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            unitActive   <= '0;
            playerFreeze <= 1'b0;
            gameOver     <= 1'b0;
            gameWon      <= 1'b0;
        end else begin
            unitActive   <= unit_active_nxt;
            playerFreeze <= player_freeze_nxt;
            gameOver     <= game_over_nxt;
            gameWon      <= game_won_nxt;
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios plus a randomized run
// checked against a behavioural model of the game rules.
`timescale 1ns/1ps
module tb_game_sequencer;

    localparam int NUM_LEVELS  = 3;
    localparam int START_LIVES = 3;
    localparam int FREEZE      = 60;
`ifdef LEVEL_TIMER_EN
    localparam int LEVEL_TIME  = 4;
    localparam bit TIMER_ON    = 1'b1;
`else
    localparam int LEVEL_TIME  = 1800;
    localparam bit TIMER_ON    = 1'b0;
`endif

    localparam int MD_IDLE  = 0;
    localparam int MD_PLAY  = 1;
    localparam int MD_HIT   = 2;
    localparam int MD_CLEAR = 3;
    localparam int MD_OVER  = 4;
    localparam int MD_WON   = 5;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        startGame = 1'b0;
    logic        col_player_ball = 1'b0;
    logic        anyBallVisible = 1'b0;
    logic [2:0]  unitActive;
    logic [1:0]  level;
    logic [2:0]  lives;
    logic        playerFreeze;
    logic        gameOver;
    logic        gameWon;
    logic [11:0] timeLeft;

    int checks = 0;
    int errors = 0;

    // behavioural model of the game
    int m_mode   = MD_IDLE;
    int m_level  = 0;
    int m_lives  = 0;
    int m_freeze = 0;
    int m_time   = 0;
    bit m_seen   = 1'b0;

    game_sequencer #(
        .NUM_LEVELS        (NUM_LEVELS),
        .START_LIVES       (START_LIVES),
        .FREEZE_FRAMES     (FREEZE),
        .LEVEL_TIME_FRAMES (LEVEL_TIME)
    ) dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .startGame       (startGame),
        .col_player_ball (col_player_ball),
        .anyBallVisible  (anyBallVisible),
        .unitActive      (unitActive),
        .level           (level),
        .lives           (lives),
        .playerFreeze    (playerFreeze),
        .gameOver        (gameOver),
        .gameWon         (gameWon),
        .timeLeft        (timeLeft)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_mode = MD_IDLE; m_level = 0; m_lives = 0;
        m_freeze = 0; m_time = 0; m_seen = 1'b0;
    endfunction

    function automatic void model_enter_play();
        m_mode = MD_PLAY;
        m_seen = 1'b0;
        if (TIMER_ON) m_time = LEVEL_TIME;
    endfunction

    // One clock of game rules, applied to the inputs seen before the edge.
    function automatic void model_step(input logic sof, input logic sg,
                                       input logic col, input logic vis);
        bit expired;
        case (m_mode)
            MD_IDLE, MD_OVER, MD_WON: begin
                if (sg) begin
                    m_level = 0;
                    m_lives = START_LIVES;
                    model_enter_play();
                end
            end
            MD_PLAY: begin
                expired = TIMER_ON && (m_time == 0);
                if (TIMER_ON && sof && m_time > 0) m_time = m_time - 1;
                if (col || expired) begin
                    if (m_lives > 0) m_lives = m_lives - 1;
                    m_mode = MD_HIT;
                    m_freeze = FREEZE;
                end else if (m_seen && !vis) begin
                    m_mode = MD_CLEAR;
                    m_freeze = FREEZE;
                end else if (vis) begin
                    m_seen = 1'b1;
                end
            end
            MD_HIT: begin
                if (m_freeze == 0) begin
                    if (m_lives == 0) m_mode = MD_OVER;
                    else model_enter_play();
                end else if (sof) begin
                    m_freeze = m_freeze - 1;
                end
            end
            MD_CLEAR: begin
                if (m_freeze == 0) begin
                    if (m_level == NUM_LEVELS - 1) begin
                        m_mode = MD_WON;
                    end else begin
                        m_level = m_level + 1;
                        model_enter_play();
                    end
                end else if (sof) begin
                    m_freeze = m_freeze - 1;
                end
            end
            default: m_mode = MD_IDLE;
        endcase
    endfunction

    // Apply inputs for one cycle and advance the model alongside the DUT.
    task automatic drive(input logic sof, input logic sg, input logic col, input logic vis);
        @(negedge clk);
        startOfFrame    = sof;
        startGame       = sg;
        col_player_ball = col;
        anyBallVisible  = vis;
        model_step(sof, sg, col, vis);
        @(posedge clk);
        #1;
        startOfFrame    = 1'b0;
        startGame       = 1'b0;
        col_player_ball = 1'b0;
    endtask

    task automatic run_freeze();
        repeat (FREEZE) drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 7;
        if (unitActive !== 3'b000) begin errors++; $display("FAIL reset_unitActive got %b expected 000", unitActive); end
        if (level !== 2'd0) begin errors++; $display("FAIL reset_level got %0d expected 0", level); end
        if (lives !== 3'd0) begin errors++; $display("FAIL reset_lives got %0d expected 0", lives); end
        if (playerFreeze !== 1'b0) begin errors++; $display("FAIL reset_playerFreeze got %b expected 0", playerFreeze); end
        if (gameOver !== 1'b0) begin errors++; $display("FAIL reset_gameOver got %b expected 0", gameOver); end
        if (gameWon !== 1'b0) begin errors++; $display("FAIL reset_gameWon got %b expected 0", gameWon); end
        if (timeLeft !== 12'd0) begin errors++; $display("FAIL reset_timeLeft got %0d expected 0", timeLeft); end
        @(negedge clk);
        resetN = 1'b1;
        model_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks += 2;
        if (lives !== 3'd0) begin errors++; $display("FAIL idle_lives got %0d expected 0", lives); end
        if (unitActive !== 3'b000) begin errors++; $display("FAIL idle_unitActive got %b expected 000", unitActive); end
    endtask

    task automatic test_start();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        checks += 4;
        if (unitActive !== 3'b001) begin errors++; $display("FAIL start_unitActive got %b expected 001", unitActive); end
        if (lives !== 3'd3) begin errors++; $display("FAIL start_lives got %0d expected 3", lives); end
        if (level !== 2'd0) begin errors++; $display("FAIL start_level got %0d expected 0", level); end
        if (playerFreeze !== 1'b0) begin errors++; $display("FAIL start_playerFreeze got %b expected 0", playerFreeze); end
    endtask

    task automatic test_deploy_mask();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (unitActive !== 3'b001 || playerFreeze !== 1'b0) begin
                errors++;
                $display("FAIL deploy_mask cycle %0d got unitActive %b freeze %b expected 001 0", i, unitActive, playerFreeze);
            end
        end
    endtask

    task automatic test_hit();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks += 3;
        if (lives !== 3'd2) begin errors++; $display("FAIL hit_lives got %0d expected 2", lives); end
        if (unitActive !== 3'b000) begin errors++; $display("FAIL hit_unitActive got %b expected 000", unitActive); end
        if (playerFreeze !== 1'b1) begin errors++; $display("FAIL hit_playerFreeze got %b expected 1", playerFreeze); end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (playerFreeze !== 1'b1 || unitActive !== 3'b000) begin
            errors++; $display("FAIL hit_ignore_start got freeze %b unitActive %b expected 1 000", playerFreeze, unitActive);
        end
        repeat (FREEZE) drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (playerFreeze !== 1'b1) begin errors++; $display("FAIL hit_last_frame_freeze got %b expected 1", playerFreeze); end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks += 2;
        if (unitActive !== 3'b001) begin errors++; $display("FAIL hit_redeploy_unitActive got %b expected 001", unitActive); end
        if (playerFreeze !== 1'b0) begin errors++; $display("FAIL hit_redeploy_freeze got %b expected 0", playerFreeze); end
    endtask

    task automatic test_clear();
        logic [2:0] exp_ua;
        for (int lv = 0; lv < NUM_LEVELS; lv++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (playerFreeze !== 1'b1 || unitActive !== 3'b000) begin
                errors++; $display("FAIL clear_enter lv %0d got freeze %b unitActive %b expected 1 000", lv, playerFreeze, unitActive);
            end
            run_freeze();
            if (lv < NUM_LEVELS - 1) begin
                exp_ua = 3'b001 << (lv + 1);
                checks += 2;
                if (level !== 2'(lv + 1)) begin errors++; $display("FAIL clear_level got %0d expected %0d", level, lv + 1); end
                if (unitActive !== exp_ua) begin errors++; $display("FAIL clear_unitActive got %b expected %b", unitActive, exp_ua); end
            end else begin
                checks += 3;
                if (gameWon !== 1'b1) begin errors++; $display("FAIL win_gameWon got %b expected 1", gameWon); end
                if (unitActive !== 3'b000) begin errors++; $display("FAIL win_unitActive got %b expected 000", unitActive); end
                if (level !== 2'd2) begin errors++; $display("FAIL win_level got %0d expected 2", level); end
            end
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        checks += 2;
        if (lives !== 3'd3 || unitActive !== 3'b001) begin
            errors++; $display("FAIL restart_from_win got lives %0d unitActive %b expected 3 001", lives, unitActive);
        end
        if (gameWon !== 1'b0) begin errors++; $display("FAIL restart_gameWon got %b expected 0", gameWon); end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (lives !== 3'd2 || playerFreeze !== 1'b1) begin
            errors++; $display("FAIL both_events got lives %0d freeze %b expected 2 1", lives, playerFreeze);
        end
        run_freeze();
        checks++;
        if (level !== 2'd0 || unitActive !== 3'b001) begin
            errors++; $display("FAIL both_same_level got level %0d unitActive %b expected 0 001", level, unitActive);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (unitActive !== 3'b001) begin
                errors++; $display("FAIL reentry_seen_cleared cycle %0d got %b expected 001", i, unitActive);
            end
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        run_freeze();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (lives !== 3'd0) begin errors++; $display("FAIL third_hit_lives got %0d expected 0", lives); end
        run_freeze();
        checks += 3;
        if (gameOver !== 1'b1) begin errors++; $display("FAIL over_gameOver got %b expected 1", gameOver); end
        if (lives !== 3'd0) begin errors++; $display("FAIL over_lives got %0d expected 0", lives); end
        if (unitActive !== 3'b000) begin errors++; $display("FAIL over_unitActive got %b expected 000", unitActive); end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        checks += 2;
        if (lives !== 3'd3 || unitActive !== 3'b001) begin
            errors++; $display("FAIL restart_from_over got lives %0d unitActive %b expected 3 001", lives, unitActive);
        end
        if (gameOver !== 1'b0) begin errors++; $display("FAIL restart_gameOver got %b expected 0", gameOver); end
    endtask

`ifdef LEVEL_TIMER_EN
    task automatic test_timer();
        checks++;
        if (timeLeft !== 12'd4) begin errors++; $display("FAIL timer_load got %0d expected 4", timeLeft); end
        repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks += 2;
        if (timeLeft !== 12'd0) begin errors++; $display("FAIL timer_zero got %0d expected 0", timeLeft); end
        if (unitActive !== 3'b001) begin errors++; $display("FAIL timer_still_play got %b expected 001", unitActive); end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks += 2;
        if (playerFreeze !== 1'b1) begin errors++; $display("FAIL timeout_freeze got %b expected 1", playerFreeze); end
        if (lives !== 3'd2) begin errors++; $display("FAIL timeout_lives got %0d expected 2", lives); end
    endtask
`endif

    task automatic test_reset_mid_freeze();
        if (m_mode == MD_PLAY) drive(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (10) drive(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        resetN = 1'b0;
        #1;
        checks++;
        if (unitActive !== 3'b000 || level !== 2'd0 || lives !== 3'd0 || playerFreeze !== 1'b0 ||
            gameOver !== 1'b0 || gameWon !== 1'b0 || timeLeft !== 12'd0) begin
            errors++;
            $display("FAIL mid_freeze_reset got ua %b lv %0d li %0d fr %b go %b gw %b tl %0d expected all 0",
                     unitActive, level, lives, playerFreeze, gameOver, gameWon, timeLeft);
        end
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (playerFreeze !== 1'b0 || unitActive !== 3'b000 || lives !== 3'd0) begin
            errors++; $display("FAIL after_reset_idle got freeze %b ua %b lives %0d expected 0 000 0", playerFreeze, unitActive, lives);
        end
    endtask

    task automatic test_random();
        logic sof, sg, col, vis;
        logic [2:0] exp_ua;
        vis = 1'b0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            sof = ($urandom_range(0, 2) == 0);
            sg  = ($urandom_range(0, 15) == 0);
            col = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 5) == 0) vis = ~vis;
            drive(sof, sg, col, vis);
            exp_ua = (m_mode == MD_PLAY) ? (3'b001 << m_level) : 3'b000;
            checks += 7;
            if (unitActive !== exp_ua) begin errors++; $display("FAIL rand_unitActive cyc %0d got %b expected %b", cyc, unitActive, exp_ua); end
            if (level !== 2'(m_level)) begin errors++; $display("FAIL rand_level cyc %0d got %0d expected %0d", cyc, level, m_level); end
            if (lives !== 3'(m_lives)) begin errors++; $display("FAIL rand_lives cyc %0d got %0d expected %0d", cyc, lives, m_lives); end
            if (playerFreeze !== (m_mode == MD_HIT || m_mode == MD_CLEAR)) begin
                errors++; $display("FAIL rand_playerFreeze cyc %0d got %b mode %0d", cyc, playerFreeze, m_mode);
            end
            if (gameOver !== (m_mode == MD_OVER)) begin errors++; $display("FAIL rand_gameOver cyc %0d got %b mode %0d", cyc, gameOver, m_mode); end
            if (gameWon !== (m_mode == MD_WON)) begin errors++; $display("FAIL rand_gameWon cyc %0d got %b mode %0d", cyc, gameWon, m_mode); end
            if (timeLeft !== 12'(m_time)) begin errors++; $display("FAIL rand_timeLeft cyc %0d got %0d expected %0d", cyc, timeLeft, m_time); end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_deploy_mask();
        test_hit();
        test_clear();
        test_simultaneous();
`ifdef LEVEL_TIMER_EN
        test_timer();
`endif
        test_reset_mid_freeze();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
